vram_host_port: RTL and testbench

- Host-side VRAM writer/reader: the counterpart to the video generator, which only reads VRAM.
- Implements the port A/B register set: ADDR, DATA and INCR for each port, plus OP_COUNT fill.
- Translates host register accesses into VRAM read/write cycles.
- Uses only the cycles in which the video generator grants the bus via its blit-cycle output.
- Sits between the host bus decoder and the VRAM arbiter mux.

---
 rtl/vram_host_port.sv | 258 +++++++++++++++++++++++++
 tb/tb_vram_host_port.sv | 429 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_host_port.sv
`default_nettype none
// ============================================================================
//  Module   : vram_host_port
//  Purpose  : Host-side VRAM reader/writer. Implements the port A/B register
//             set (ADDR, DATA, INCR per port, plus OP_COUNT fill) and turns
//             host register accesses into VRAM read/write cycles. VRAM
//             accesses are only launched in slots granted by the video
//             generator through blit_cycle_i.
//  Ports    : clk, reset_n_i       - pixel clock, async active-low reset
//             blit_cycle_i         - VRAM slot grant from video generator
//             reg_wr_i / reg_rd_i  - host register write / read strobes
//             reg_num_i            - register number (7,9,A,B,D,E,F)
//             reg_data_i / _o      - host write data / registered read data
//             busy_o               - operation pending or in flight
//             vram_sel_o, vram_wr_o, vram_addr_o, vram_data_o - VRAM request
//             vram_data_i          - VRAM read data (one cycle after select)
//  Revision : 1.0 - initial release
// ============================================================================
module vram_host_port #(
    parameter int                ADDR_W     = 16,
    parameter int                DATA_W     = 16,
    parameter logic [ADDR_W-1:0] INCR_RESET = 16'h0001
) (
    input  logic              clk,
    input  logic              reset_n_i,
    input  logic              blit_cycle_i,
    input  logic              reg_wr_i,
    input  logic              reg_rd_i,
    input  logic [3:0]        reg_num_i,
    input  logic [15:0]       reg_data_i,
    output logic [15:0]       reg_data_o,
    output logic              busy_o,
    output logic              vram_sel_o,
    output logic              vram_wr_o,
    output logic [ADDR_W-1:0] vram_addr_o,
    output logic [DATA_W-1:0] vram_data_o,
    input  logic [DATA_W-1:0] vram_data_i
);

    localparam logic [3:0] c_REG_OP_COUNT = 4'h7;
    localparam logic [3:0] c_REG_ADDR_A   = 4'h9;
    localparam logic [3:0] c_REG_DATA_A   = 4'hA;
    localparam logic [3:0] c_REG_INCR_A   = 4'hB;
    localparam logic [3:0] c_REG_ADDR_B   = 4'hD;
    localparam logic [3:0] c_REG_DATA_B   = 4'hE;
    localparam logic [3:0] c_REG_INCR_B   = 4'hF;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_FILL    = 2'd2,
        S_RD_WAIT = 2'd3
    } state_t;

    state_t              r_state, w_next;
    logic                r_busy;
    logic [ADDR_W-1:0]   r_addr_a, r_addr_b, r_incr_a, r_incr_b;
    logic [DATA_W-1:0]   r_rd_a, r_rd_b, r_data_b, r_wdata;
    logic [15:0]         r_fill_cnt;
    logic                r_port_b;   // port owning the pending operation
    logic                r_pend_wr;  // ISSUE performs a write (1) or prefetch (0)
    logic                r_cap;      // read data is on vram_data_i this cycle
    logic                r_sel, r_wr;
    logic [ADDR_W-1:0]   r_vaddr;
    logic [DATA_W-1:0]   r_vdata;
    logic [15:0]         r_rdata;

    logic                w_wr_ok, w_rd_ok, w_start;
    logic                w_issue_wr, w_issue_rd, w_capture;
    logic [ADDR_W-1:0]   w_port_addr;
    logic [15:0]         w_rd_val;

    // Register accesses only take effect while idle; a simultaneous read
    // is dropped in favour of the write.
    assign w_wr_ok     = reg_wr_i && !r_busy;
    assign w_rd_ok     = reg_rd_i && !reg_wr_i && !r_busy;
    assign w_port_addr = r_port_b ? r_addr_b : r_addr_a;

    always_comb begin
        w_rd_val = '0;
        case (reg_num_i)
            c_REG_OP_COUNT: w_rd_val = r_fill_cnt;
            c_REG_ADDR_A:   w_rd_val = 16'(r_addr_a);
            c_REG_DATA_A:   w_rd_val = 16'(r_rd_a);
            c_REG_INCR_A:   w_rd_val = 16'(r_incr_a);
            c_REG_ADDR_B:   w_rd_val = 16'(r_addr_b);
            c_REG_DATA_B:   w_rd_val = 16'(r_rd_b);
            c_REG_INCR_B:   w_rd_val = 16'(r_incr_b);
            default:        w_rd_val = '0;
        endcase
    end

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_busy  <= (w_next != S_IDLE);
        end
    end

    always_comb begin
        w_next     = r_state;
        w_start    = 1'b0;
        w_issue_wr = 1'b0;
        w_issue_rd = 1'b0;
        w_capture  = 1'b0;
        if (w_wr_ok) begin
            case (reg_num_i)
                c_REG_ADDR_A, c_REG_DATA_A,
                c_REG_ADDR_B, c_REG_DATA_B: w_start = 1'b1;
                c_REG_OP_COUNT:             w_start = (reg_data_i != 16'd0);
                default:                    w_start = 1'b0;
            endcase
        end
        if (w_rd_ok && (reg_num_i == c_REG_DATA_A || reg_num_i == c_REG_DATA_B))
            w_start = 1'b1;
        case (r_state)
            S_IDLE: begin
                if (w_start) w_next = S_ISSUE;
            end
            S_ISSUE: begin
                if (blit_cycle_i) begin
                    if (r_pend_wr) begin
                        w_issue_wr = 1'b1;
                        // Count still > 0 after this write: keep filling.
                        w_next = (r_fill_cnt > 16'd1) ? S_FILL : S_ISSUE;
                    end else begin
                        w_issue_rd = 1'b1;
                        w_next     = S_RD_WAIT;
                    end
                end
            end
            S_FILL: begin
                if (blit_cycle_i) begin
                    w_issue_wr = 1'b1;
                    if (r_fill_cnt == 16'd1) w_next = S_ISSUE;
                end
            end
            S_RD_WAIT: begin
                if (r_cap) begin
                    w_capture = 1'b1;
                    w_next    = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // ----------------------------------------------------------- datapath
    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_addr_a   <= '0;
            r_addr_b   <= '0;
            r_incr_a   <= INCR_RESET;
            r_incr_b   <= INCR_RESET;
            r_rd_a     <= '0;
            r_rd_b     <= '0;
            r_data_b   <= '0;
            r_wdata    <= '0;
            r_fill_cnt <= '0;
            r_port_b   <= 1'b0;
            r_pend_wr  <= 1'b0;
            r_cap      <= 1'b0;
            r_sel      <= 1'b0;
            r_wr       <= 1'b0;
            r_vaddr    <= '0;
            r_vdata    <= '0;
            r_rdata    <= '0;
        end else begin
            r_sel <= 1'b0;
            r_cap <= r_sel & ~r_wr;
            if (reg_rd_i && !reg_wr_i) r_rdata <= w_rd_val;

            if (w_wr_ok) begin
                case (reg_num_i)
                    c_REG_ADDR_A: begin
                        r_addr_a  <= ADDR_W'(reg_data_i);
                        r_port_b  <= 1'b0;
                        r_pend_wr <= 1'b0;
                    end
                    c_REG_DATA_A: begin
                        r_wdata   <= DATA_W'(reg_data_i);
                        r_port_b  <= 1'b0;
                        r_pend_wr <= 1'b1;
                    end
                    c_REG_INCR_A: r_incr_a <= ADDR_W'(reg_data_i);
                    c_REG_ADDR_B: begin
                        r_addr_b  <= ADDR_W'(reg_data_i);
                        r_port_b  <= 1'b1;
                        r_pend_wr <= 1'b0;
                    end
                    c_REG_DATA_B: begin
                        r_wdata   <= DATA_W'(reg_data_i);
                        r_data_b  <= DATA_W'(reg_data_i);
                        r_port_b  <= 1'b1;
                        r_pend_wr <= 1'b1;
                    end
                    c_REG_INCR_B: r_incr_b <= ADDR_W'(reg_data_i);
                    c_REG_OP_COUNT: begin
                        if (reg_data_i != 16'd0) begin
                            r_fill_cnt <= reg_data_i;
                            r_wdata    <= r_data_b;
                            r_port_b   <= 1'b1;
                            r_pend_wr  <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end

            // Reading DATA_x consumes the prefetched word and fetches the next.
            if (w_rd_ok && reg_num_i == c_REG_DATA_A) begin
                r_addr_a  <= r_addr_a + r_incr_a;
                r_port_b  <= 1'b0;
                r_pend_wr <= 1'b0;
            end
            if (w_rd_ok && reg_num_i == c_REG_DATA_B) begin
                r_addr_b  <= r_addr_b + r_incr_b;
                r_port_b  <= 1'b1;
                r_pend_wr <= 1'b0;
            end

            if (w_issue_wr) begin
                r_sel     <= 1'b1;
                r_wr      <= 1'b1;
                r_vaddr   <= w_port_addr;
                r_vdata   <= r_wdata;
                r_pend_wr <= 1'b0;
                if (r_port_b) r_addr_b <= r_addr_b + r_incr_b;
                else          r_addr_a <= r_addr_a + r_incr_a;
                if (r_fill_cnt != 16'd0) r_fill_cnt <= r_fill_cnt - 16'd1;
            end

            if (w_issue_rd) begin
                r_sel   <= 1'b1;
                r_wr    <= 1'b0;
                r_vaddr <= w_port_addr;
            end

            if (w_capture) begin
                if (r_port_b) r_rd_b <= vram_data_i;
                else          r_rd_a <= vram_data_i;
            end
        end
    end

    assign reg_data_o  = r_rdata;
    assign busy_o      = r_busy;
    assign vram_sel_o  = r_sel;
    assign vram_wr_o   = r_wr;
    assign vram_addr_o = r_vaddr;
    assign vram_data_o = r_vdata;

endmodule
`default_nettype wire

// File: tb/tb_vram_host_port.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vram_host_port
//  Purpose  : Self-checking bench for vram_host_port with a VRAM model and a
//             register-level reference model of ports A/B.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_vram_host_port;

    logic        clk = 1'b0;
    logic        reset_n_i;
    logic        blit_cycle_i;
    logic        reg_wr_i, reg_rd_i;
    logic [3:0]  reg_num_i;
    logic [15:0] reg_data_i, reg_data_o;
    logic        busy_o, vram_sel_o, vram_wr_o;
    logic [15:0] vram_addr_o, vram_data_o, vram_data_i;

    vram_host_port dut (
        .clk          (clk),
        .reset_n_i    (reset_n_i),
        .blit_cycle_i (blit_cycle_i),
        .reg_wr_i     (reg_wr_i),
        .reg_rd_i     (reg_rd_i),
        .reg_num_i    (reg_num_i),
        .reg_data_i   (reg_data_i),
        .reg_data_o   (reg_data_o),
        .busy_o       (busy_o),
        .vram_sel_o   (vram_sel_o),
        .vram_wr_o    (vram_wr_o),
        .vram_addr_o  (vram_addr_o),
        .vram_data_o  (vram_data_o),
        .vram_data_i  (vram_data_i)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int blit_mode = 0;   // 0: 2 high / 2 low, 1: random, 2: always granted
    int blit_viol = 0;   // accesses not preceded by a granted cycle
    logic b_last = 1'b0;

    logic [32:0] acc_q[$];   // observed {wr, addr, data}; data 0 for reads
    logic [32:0] exp_q[$];   // expected accesses from the reference model
    logic [15:0] vmem[logic [15:0]];
    logic [15:0] rmem[logic [15:0]];
    logic [15:0] m_addr[2], m_incr[2], m_rd[2], m_data_b;

    function automatic logic [15:0] init_val(input logic [15:0] a);
        return a ^ 16'hA5C3;
    endfunction

    // Blit grant generator
    initial begin : blit_gen
        int ph;
        ph = 0;
        blit_cycle_i = 1'b0;
        forever begin
            @(negedge clk);
            case (blit_mode)
                0:       blit_cycle_i = (ph < 2);
                1:       blit_cycle_i = 1'($urandom_range(0, 1));
                default: blit_cycle_i = 1'b1;
            endcase
            ph = (ph + 1) % 4;
        end
    end

    // Synchronous VRAM model plus access logger
    always @(posedge clk) begin
        if (vram_sel_o === 1'b1) begin
            if (!b_last) blit_viol++;
            if (vram_wr_o) begin
                vmem[vram_addr_o] = vram_data_o;
                acc_q.push_back({1'b1, vram_addr_o, vram_data_o});
            end else begin
                vram_data_i <= vmem.exists(vram_addr_o) ? vmem[vram_addr_o] : init_val(vram_addr_o);
                acc_q.push_back({1'b0, vram_addr_o, 16'h0000});
            end
        end
        b_last <= blit_cycle_i;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------ reference model
    function automatic logic [15:0] rget(input logic [15:0] a);
        return rmem.exists(a) ? rmem[a] : init_val(a);
    endfunction

    task automatic m_reset();
        m_addr[0] = 16'h0; m_addr[1] = 16'h0;
        m_incr[0] = 16'h1; m_incr[1] = 16'h1;
        m_rd[0]   = 16'h0; m_rd[1]   = 16'h0;
        m_data_b  = 16'h0;
    endtask

    task automatic m_prefetch(input int p);
        exp_q.push_back({1'b0, m_addr[p], 16'h0000});
        m_rd[p] = rget(m_addr[p]);
    endtask

    task automatic m_write(input int p, input logic [15:0] d);
        exp_q.push_back({1'b1, m_addr[p], d});
        rmem[m_addr[p]] = d;
        m_addr[p] = m_addr[p] + m_incr[p];
    endtask

    // ------------------------------------------------------ host drivers
    task automatic host_wr(input logic [3:0] n, input logic [15:0] d);
        @(negedge clk);
        reg_wr_i = 1'b1; reg_num_i = n; reg_data_i = d;
        @(negedge clk);
        reg_wr_i = 1'b0;
    endtask

    task automatic host_rd(input logic [3:0] n, output logic [15:0] v);
        @(negedge clk);
        reg_rd_i = 1'b1; reg_num_i = n;
        @(negedge clk);
        reg_rd_i = 1'b0;
        v = reg_data_o;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy_o === 1'b1 && n < 500) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (busy_o !== 1'b0) begin
            errors++;
            $display("FAIL wait_idle: busy_o=%b after %0d cycles, required 0", busy_o, n);
        end
    endtask

    // Accepted write while idle: drive DUT and advance the model.
    task automatic do_wr(input logic [3:0] n, input logic [15:0] d);
        host_wr(n, d);
        case (n)
            4'h9: begin m_addr[0] = d; m_prefetch(0); end
            4'hA: begin m_write(0, d); m_prefetch(0); end
            4'hB: m_incr[0] = d;
            4'hD: begin m_addr[1] = d; m_prefetch(1); end
            4'hE: begin m_data_b = d; m_write(1, d); m_prefetch(1); end
            4'hF: m_incr[1] = d;
            4'h7: if (d != 16'h0) begin
                      repeat (int'(d)) m_write(1, m_data_b);
                      m_prefetch(1);
                  end
            default: ;
        endcase
        wait_idle();
    endtask

    task automatic do_rd(input logic [3:0] n, output logic [15:0] got, output logic [15:0] exp);
        host_rd(n, got);
        case (n)
            4'h9: exp = m_addr[0];
            4'hA: begin exp = m_rd[0]; m_addr[0] = m_addr[0] + m_incr[0]; m_prefetch(0); end
            4'hB: exp = m_incr[0];
            4'hD: exp = m_addr[1];
            4'hE: begin exp = m_rd[1]; m_addr[1] = m_addr[1] + m_incr[1]; m_prefetch(1); end
            4'hF: exp = m_incr[1];
            default: exp = 16'h0;   // OP_COUNT is 0 whenever idle
        endcase
        wait_idle();
    endtask

    // ------------------------------------------------------------- tests
    task automatic test_reset();
        logic [15:0] got, exp;
        reset_n_i = 1'b0; reg_wr_i = 1'b0; reg_rd_i = 1'b0;
        reg_num_i = 4'h0; reg_data_i = 16'h0;
        m_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({reg_data_o, busy_o, vram_sel_o, vram_wr_o, vram_addr_o, vram_data_o} !== 51'h0) begin
            errors++;
            $display("FAIL reset_outputs: got rdata=%h busy=%b sel=%b wr=%b addr=%h data=%h, required all 0",
                     reg_data_o, busy_o, vram_sel_o, vram_wr_o, vram_addr_o, vram_data_o);
        end
        reset_n_i = 1'b1;
        do_rd(4'hB, got, exp);
        checks++;
        if (got !== 16'h0001) begin errors++; $display("FAIL reset_incr_a: got %h, required 0001", got); end
        do_rd(4'h9, got, exp);
        checks++;
        if (got !== 16'h0000) begin errors++; $display("FAIL reset_addr_a: got %h, required 0000", got); end
        do_rd(4'hF, got, exp);
        checks++;
        if (got !== exp) begin errors++; $display("FAIL reset_incr_b: got %h, required %h", got, exp); end
        checks++;
        if (busy_o !== 1'b0 || acc_q.size() != 0) begin
            errors++;
            $display("FAIL reset_idle: busy=%b accesses=%0d, required 0 and 0", busy_o, acc_q.size());
        end
    endtask

    task automatic test_single_write();
        logic [15:0] got, exp;
        blit_mode = 0;
        blit_viol = 0;
        do_wr(4'h9, 16'h0100);
        do_wr(4'hA, 16'hABCD);
        checks++;
        if (acc_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL single_write_count: got %0d accesses, required %0d", acc_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < acc_q.size(); i++)
                if (acc_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL single_write_access[%0d]: got %h, required %h", i, acc_q[i], exp_q[i]);
                    break;
                end
        end
        checks++;
        if (acc_q.size() < 2 || acc_q[1] !== {1'b1, 16'h0100, 16'hABCD}) begin
            errors++;
            $display("FAIL single_write_op: got %h, required 10100abcd", acc_q.size() > 1 ? acc_q[1] : 33'h0);
        end
        acc_q.delete(); exp_q.delete();
        do_rd(4'h9, got, exp);
        checks++;
        if (got !== 16'h0101) begin errors++; $display("FAIL single_write_addr: got %h, required 0101", got); end
        checks++;
        if (blit_viol != 0) begin errors++; $display("FAIL blit_grant: got %0d ungranted accesses, required 0", blit_viol); end
    endtask

    task automatic test_prefetch();
        logic [15:0] got, exp;
        blit_mode = 0;
        do_wr(4'hB, 16'h0002);
        do_wr(4'h9, 16'h0200);
        do_wr(4'hA, 16'h1234);
        do_wr(4'hA, 16'h5678);
        do_wr(4'h9, 16'h0200);
        do_rd(4'hA, got, exp);
        checks++;
        if (got !== 16'h1234 || got !== exp) begin
            errors++; $display("FAIL prefetch_first: got %h, required 1234", got);
        end
        do_rd(4'hA, got, exp);
        checks++;
        if (got !== 16'h5678 || got !== exp) begin
            errors++; $display("FAIL prefetch_second: got %h, required 5678", got);
        end
        checks++;
        if (acc_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL prefetch_count: got %0d accesses, required %0d", acc_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < acc_q.size(); i++)
                if (acc_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL prefetch_access[%0d]: got %h, required %h", i, acc_q[i], exp_q[i]);
                    break;
                end
        end
        acc_q.delete(); exp_q.delete();
    endtask

    task automatic test_fill_wrap();
        logic [15:0] got, exp;
        blit_mode = 1;
        do_wr(4'hD, 16'hFFFE);
        do_wr(4'hF, 16'h0001);
        do_wr(4'hE, 16'h00FF);
        acc_q.delete(); exp_q.delete();
        do_wr(4'h7, 16'd3);
        checks++;
        if (acc_q.size() != 4 || acc_q[0] !== {1'b1, 16'hFFFF, 16'h00FF} ||
            acc_q[1] !== {1'b1, 16'h0000, 16'h00FF} || acc_q[2] !== {1'b1, 16'h0001, 16'h00FF} ||
            acc_q[3] !== {1'b0, 16'h0002, 16'h0000}) begin
            errors++;
            $display("FAIL fill_wrap_accesses: got %0d accesses, required writes FFFF,0000,0001 then read 0002",
                     acc_q.size());
        end
        acc_q.delete(); exp_q.delete();
        do_rd(4'hD, got, exp);
        checks++;
        if (got !== 16'h0002) begin errors++; $display("FAIL fill_wrap_addr_b: got %h, required 0002", got); end
        host_wr(4'h7, 16'd0);
        checks++;
        if (busy_o !== 1'b0) begin errors++; $display("FAIL fill_zero_busy: got %b, required 0", busy_o); end
        repeat (10) @(negedge clk);
        checks++;
        if (acc_q.size() != 0) begin errors++; $display("FAIL fill_zero_access: got %0d, required 0", acc_q.size()); end
    endtask

    task automatic test_busy_ignore();
        logic [15:0] got, exp;
        blit_mode = 0;
        host_wr(4'h9, 16'h0300);
        m_addr[0] = 16'h0300; m_prefetch(0);
        checks++;
        if (busy_o !== 1'b1) begin errors++; $display("FAIL busy_rise: got %b, required 1", busy_o); end
        host_wr(4'h9, 16'h0400);   // must be ignored
        wait_idle();
        do_rd(4'h9, got, exp);
        checks++;
        if (got !== 16'h0300) begin errors++; $display("FAIL busy_ignore_addr: got %h, required 0300", got); end
        checks++;
        if (acc_q.size() != 1 || acc_q[0] !== exp_q[0]) begin
            errors++; $display("FAIL busy_ignore_access: got %0d accesses, required 1", acc_q.size());
        end
        acc_q.delete(); exp_q.delete();
        @(negedge clk);
        reg_wr_i = 1'b1; reg_rd_i = 1'b1; reg_num_i = 4'hB; reg_data_i = 16'h0005;
        @(negedge clk);
        reg_wr_i = 1'b0; reg_rd_i = 1'b0;
        m_incr[0] = 16'h0005;
        checks++;
        if (reg_data_o !== 16'h0300) begin errors++; $display("FAIL wr_rd_hold: got %h, required 0300", reg_data_o); end
        do_rd(4'hB, got, exp);
        checks++;
        if (got !== 16'h0005) begin errors++; $display("FAIL wr_rd_write: got %h, required 0005", got); end
    endtask

    task automatic test_random();
        logic [15:0] got, exp, d;
        logic [3:0]  n;
        logic [3:0]  wr_regs[8] = '{4'h7, 4'h9, 4'hA, 4'hB, 4'hD, 4'hE, 4'hF, 4'h3};
        int          bad_rd, bad_acc;
        blit_mode = 1;
        bad_rd = 0; bad_acc = 0;
        for (int it = 0; it < 60; it++) begin
            if ($urandom_range(0, 1) == 0) begin
                n = wr_regs[$urandom_range(0, 7)];
                case (n)
                    4'h7:       d = 16'($urandom_range(0, 4));
                    4'hB, 4'hF: d = ($urandom_range(0, 4) == 4) ? 16'hFFFF : 16'($urandom_range(0, 3));
                    default:    d = 16'($urandom);
                endcase
                do_wr(n, d);
            end else begin
                n = 4'($urandom_range(0, 15));
                do_rd(n, got, exp);
                checks++;
                if (got !== exp) begin
                    errors++;
                    if (bad_rd++ < 5) $display("FAIL random_read reg %h: got %h, required %h", n, got, exp);
                end
            end
            checks++;
            if (acc_q.size() != exp_q.size()) begin
                errors++;
                if (bad_acc++ < 5) $display("FAIL random_access_count op %0d: got %0d, required %0d",
                                            it, acc_q.size(), exp_q.size());
            end else begin
                for (int i = 0; i < acc_q.size(); i++)
                    if (acc_q[i] !== exp_q[i]) begin
                        errors++;
                        if (bad_acc++ < 5) $display("FAIL random_access op %0d: got %h, required %h",
                                                    it, acc_q[i], exp_q[i]);
                        break;
                    end
            end
            acc_q.delete(); exp_q.delete();
        end
        checks++;
        if (blit_viol != 0) begin errors++; $display("FAIL random_blit_grant: got %0d, required 0", blit_viol); end
    endtask

    task automatic test_reset_midfill();
        logic [15:0] got, exp;
        int n, nw;
        blit_mode = 2;
        do_wr(4'hF, 16'h0001);
        do_wr(4'hD, 16'h1000);
        acc_q.delete(); exp_q.delete();
        host_wr(4'h7, 16'd10);
        n = 0; nw = 0;
        while (nw < 4 && n < 200) begin
            @(negedge clk);
            n++;
            nw = 0;
            foreach (acc_q[i]) if (acc_q[i][32]) nw++;
        end
        checks++;
        if (nw < 4) begin errors++; $display("FAIL midfill_progress: got %0d writes, required 4", nw); end
        #2;
        reset_n_i = 1'b0;
        #1;
        checks++;
        if ({reg_data_o, busy_o, vram_sel_o, vram_wr_o, vram_addr_o, vram_data_o} !== 51'h0) begin
            errors++;
            $display("FAIL midfill_async_reset: got busy=%b sel=%b wr=%b addr=%h data=%h rdata=%h, required all 0",
                     busy_o, vram_sel_o, vram_wr_o, vram_addr_o, vram_data_o, reg_data_o);
        end
        repeat (2) @(negedge clk);
        reset_n_i = 1'b1;
        m_reset();
        repeat (20) @(negedge clk);
        checks++;
        if (busy_o !== 1'b0 || acc_q.size() != 4) begin
            errors++;
            $display("FAIL midfill_after_release: busy=%b accesses=%0d, required 0 and 4", busy_o, acc_q.size());
        end
        do_rd(4'h7, got, exp);
        checks++;
        if (got !== 16'h0000) begin errors++; $display("FAIL midfill_op_count: got %h, required 0000", got); end
        do_rd(4'hD, got, exp);
        checks++;
        if (got !== 16'h0000) begin errors++; $display("FAIL midfill_addr_b: got %h, required 0000", got); end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_prefetch();
        test_fill_wrap();
        test_busy_ignore();
        test_random();
        test_reset_midfill();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
